// File: rtl/gate_seq_checker_if.sv
// rtl/gate_seq_checker_if.sv - stimulus/check bus between the sequencer and its gate harness
interface gate_seq_checker_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  // Harness side: requests runs and returns the gate output.
  modport master (
    output start,
    output y_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec
  );

  // Sequencer side: drives the gate inputs and reports the verdict.
  modport slave (
    input  start,
    input  y_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec
  );
endinterface

// File: rtl/gate_seq_checker.sv
// rtl/gate_seq_checker.sv - walks a 2-input gate through 00..11 and checks y against a truth table
module gate_seq_checker #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] EXPECT      = 4'b1110
) (
  input  logic              clk,
  input  logic              rst,
  gate_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Last settle count before the sample cycle; HOLD_CYCLES is limited to 1..255.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] hold_cnt;
  logic       a_r;
  logic       b_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [2:0] err_r;
  logic [3:0] fail_r;

  logic       mismatch;
  logic [3:0] fail_next;

  // Only meaningful in SAMPLE; elsewhere y_in is ignored.
  assign mismatch = (bus.y_in != EXPECT[idx]);

  // Fail map including the vector being sampled, so DONE can judge pass in one step.
  always_comb begin
    fail_next = fail_r;
    if (mismatch) begin
      fail_next[idx] = 1'b1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      hold_cnt <= 8'd0;
      a_r      <= 1'b0;
      b_r      <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= 3'd0;
      fail_r   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          a_r    <= 1'b0;
          b_r    <= 1'b0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            state    <= DRIVE;
            idx      <= 2'd0;
            hold_cnt <= 8'd0;
            err_r    <= 3'd0;
            fail_r   <= 4'd0;
            pass_r   <= 1'b0;
            busy_r   <= 1'b1;
          end
        end

        DRIVE: begin
          {a_r, b_r} <= idx;
          hold_cnt   <= hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          fail_r <= fail_next;
          if (mismatch) begin
            err_r <= err_r + 3'd1;
          end
          if (idx == 2'd3) begin
            state  <= DONE;
            done_r <= 1'b1;
            pass_r <= (fail_next == 4'd0);
            a_r    <= 1'b0;
            b_r    <= 1'b0;
          end else begin
            state      <= DRIVE;
            idx        <= idx + 2'd1;
            hold_cnt   <= 8'd0;
            {a_r, b_r} <= idx + 2'd1;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
          a_r    <= 1'b0;
          b_r    <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_r;
  assign bus.fail_vec  = fail_r;

endmodule

// File: tb/tb_gate_seq_checker.sv
// tb/tb_gate_seq_checker.sv - scoreboard bench for gate_seq_checker
module tb_gate_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_seq_checker_if bus1();
  gate_seq_checker_if bus2();

  gate_seq_checker #(.HOLD_CYCLES(4), .EXPECT(4'b1110)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  gate_seq_checker #(.HOLD_CYCLES(1), .EXPECT(4'b1110)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Gate under test for dut1: 0 = OR, 1 = stuck at 0, 2 = AND
  int gmode = 0;
  always_comb begin
    case (gmode)
      0:       bus1.y_in = bus1.a_out | bus1.b_out;
      1:       bus1.y_in = 1'b0;
      default: bus1.y_in = bus1.a_out & bus1.b_out;
    endcase
  end
  always_comb bus2.y_in = bus2.a_out | bus2.b_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] fv;
    logic [2:0] ec;
    logic       pass;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t m1;
  exp_t m2;

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s act=%0d exp=%0d at cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor for dut1: every done pulse is matched against the oldest expected run
  always @(negedge clk) begin
    if (!rst && bus1.done) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        m1 = q1.pop_front();
        chk("dut1_done_cycle", cyc, m1.cyc);
        chk("dut1_fail_vec", int'(bus1.fail_vec), int'(m1.fv));
        chk("dut1_err_count", int'(bus1.err_count), int'(m1.ec));
        chk("dut1_pass", int'(bus1.pass), int'(m1.pass));
        chk("dut1_busy_at_done", int'(bus1.busy), 1);
      end
    end
  end

  // Monitor for dut2
  always @(negedge clk) begin
    if (!rst && bus2.done) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_done", 1, 0);
      end else begin
        m2 = q2.pop_front();
        chk("dut2_done_cycle", cyc, m2.cyc);
        chk("dut2_fail_vec", int'(bus2.fail_vec), int'(m2.fv));
        chk("dut2_err_count", int'(bus2.err_count), int'(m2.ec));
        chk("dut2_pass", int'(bus2.pass), int'(m2.pass));
        chk("dut2_busy_at_done", int'(bus2.busy), 1);
      end
    end
  end

  function automatic int get_ab(input int which);
    if (which == 2) return int'({bus2.a_out, bus2.b_out});
    return int'({bus1.a_out, bus1.b_out});
  endfunction

  function automatic int get_busy(input int which);
    if (which == 2) return int'(bus2.busy);
    return int'(bus1.busy);
  endfunction

  function automatic int hold_of(input int which);
    return (which == 2) ? 1 : 4;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 2) bus2.start = v;
    else bus1.start = v;
  endtask

  task automatic push_exp(input int which, input int c, input logic [3:0] fv,
                          input logic [2:0] ec, input logic p);
    exp_t e;
    e.cyc  = c;
    e.fv   = fv;
    e.ec   = ec;
    e.pass = p;
    if (which == 2) q2.push_back(e);
    else q1.push_back(e);
  endtask

  // Pulse start for one edge and queue the expected verdict for that run
  task automatic begin_run(input int which, input logic [3:0] fv, input logic [2:0] ec,
                           input logic p, output int cs);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    cs = cyc;
    push_exp(which, cs + 4 * (hold_of(which) + 1), fv, ec, p);
    set_start(which, 1'b0);
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 2) ? q2.size() : q1.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", (which == 2) ? q2.size() : q1.size(), 0);
  endtask

  // One full run with a per-cycle trace of the driven vector
  task automatic run(input int which, input logic [3:0] fv, input logic [2:0] ec,
                     input logic p, input bit repulse, input bit restart_at_done);
    int h;
    int cs;
    int last;
    h = hold_of(which);
    last = 4 * (h + 1);
    begin_run(which, fv, ec, p, cs);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (repulse) set_start(which, (k == 3) || (k == 10));
      else if (restart_at_done && k == last) set_start(which, 1'b1);
      chk("ab_trace", get_ab(which), (k == last) ? 0 : k / (h + 1));
      chk("busy_in_run", get_busy(which), 1);
    end
    if (restart_at_done) begin
      @(posedge clk);
      #1;
      chk("start_in_done_ignored", get_busy(which), 0);
      @(posedge clk);
      #1;
      chk("held_start_restarts", get_busy(which), 1);
      push_exp(which, cyc + last, fv, ec, p);
      set_start(which, 1'b0);
    end
    drain(which);
  endtask

  initial begin
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ab", get_ab(1), 0);
    chk("rst_busy", int'(bus1.busy), 0);
    chk("rst_done", int'(bus1.done), 0);
    chk("rst_pass", int'(bus1.pass), 0);
    chk("rst_err", int'(bus1.err_count), 0);
    chk("rst_fail", int'(bus1.fail_vec), 0);
    chk("rst_dut2_busy", int'(bus2.busy), 0);
    rst = 1'b0;

    // 1: OR gate, all vectors match
    gmode = 0;
    run(1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // 2: y stuck at 0; start held through DONE launches a second identical run
    gmode = 1;
    run(1, 4'b1110, 3'd3, 1'b0, 1'b0, 1'b1);

    // 3: AND gate in place of OR
    gmode = 2;
    run(1, 4'b0110, 3'd2, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("result_held_pass", int'(bus1.pass), 0);
    chk("result_held_fail", int'(bus1.fail_vec), 6);
    chk("result_held_err", int'(bus1.err_count), 2);

    // 4: start re-pulsed mid-run is ignored
    gmode = 0;
    run(1, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b0);

    // 5: reset mid-run, then a clean rerun
    begin
      int cs;
      begin_run(1, 4'b0000, 3'd0, 1'b1, cs);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      q1.delete();
      chk("midrst_ab", get_ab(1), 0);
      chk("midrst_busy", int'(bus1.busy), 0);
      chk("midrst_done", int'(bus1.done), 0);
      chk("midrst_pass", int'(bus1.pass), 0);
      chk("midrst_err", int'(bus1.err_count), 0);
      chk("midrst_fail", int'(bus1.fail_vec), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) begin
        @(negedge clk);
        chk("no_done_after_rst", int'(bus1.done), 0);
      end
      run(1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
    end

    // 6: HOLD_CYCLES=1 instance with OR gate
    run(2, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
